decode_issue: RTL and testbench

Decode/issue stage of the hazard-aware five-stage core. Consumes fetched instructions and register-file read data, and produces the registered operand pair, ALU opcode and control bundle that the EX-stage ALU consumes. Detects RAW hazards, inserts bubbles, and discards wrong-path instructions on a taken branch or jump. One instruction per cycle; one register stage of latency.

---
 rtl/decode_issue_pkg.sv | 79 +++++++
 rtl/decode_issue_imm_gen.sv | 15 +
 rtl/defines.sv | 35 +++
 rtl/decode_issue.sv | 179 +++++++++++++++++
 tb/tb_decode_issue.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_pkg.sv
// Types and helpers shared by the decode/issue stage: immediate set, EX bundle,
// source-usage and ALU-opcode selection.
`include "defines.sv"

package decode_issue_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD      = `ADD;
    localparam logic [3:0] ALU_SUB      = `SUB;
    localparam logic [3:0] ALU_SRA      = `SRA;
    localparam logic [3:0] ALU_BEQ      = `BEQ;
    localparam logic [3:0] ALU_JAL_JALR = `JAL_JALR;

    typedef struct packed {
        logic [XLEN-1:0] immI;
        logic [XLEN-1:0] immS;
        logic [XLEN-1:0] immB;
        logic [XLEN-1:0] immU;
        logic [XLEN-1:0] immJ;
    } imm_t;

    typedef struct packed {
        logic [XLEN-1:0] aluIn1;
        logic [XLEN-1:0] aluIn2;
        logic [3:0]      aluOp;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] storeData;
        logic [4:0]      rd;
        logic            we;
        logic            isLoad;
        logic            isStore;
        logic            isBranch;
        logic            illegal;
    } exBundle_t;

    function automatic exBundle_t resetBundle();
        exBundle_t b;
        b       = '0;
        b.aluOp = `ADD;
        return b;
    endfunction

    // {rs1 used, rs2 used} for a major opcode.
    function automatic logic [1:0] srcUse(input logic [6:0] opcode);
        case (opcode)
            `OP, `STORE, `BRANCH:  return 2'b11;
            `OP_IMM, `LOAD, `JALR: return 2'b10;
            default:               return 2'b00;
        endcase
    endfunction

    // instr[30] only means SUB on register-register ops; on OP-IMM it is an immediate bit.
    function automatic logic [3:0] aluOpFor(input logic [2:0] funct3, input logic alt,
                                            input logic regReg);
        case (funct3)
            3'd0:    return (alt && regReg) ? `SUB : `ADD;
            3'd1:    return `SLL;
            3'd2:    return `SLT;
            3'd3:    return `SLTU;
            3'd4:    return `XOR;
            3'd5:    return alt ? `SRA : `SRL;
            3'd6:    return `OR;
            default: return `AND;
        endcase
    endfunction

    function automatic logic [3:0] branchOp(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return `BEQ;
            3'd1:    return `BNE;
            3'd4:    return `BLT;
            3'd5:    return `BGE;
            3'd6:    return `BLTU;
            default: return `BGEU;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_imm_gen.sv
// Combinational RV32I immediate generator: I, S, B, U and J immediates from one word.
module decode_issue_imm_gen
    import decode_issue_pkg::*;
(
    input  logic [31:7] instr,
    output imm_t        imm
);

    assign imm.immI = {{20{instr[31]}}, instr[31:20]};
    assign imm.immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm.immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm.immU = {instr[31:12], 12'b0};
    assign imm.immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/defines.sv
// Shared ALU opcode and RV32I major-opcode macros used by the decode/issue stage.
// Guarded so every file of the stage can include it.
`ifndef DEFINES_SV
`define DEFINES_SV

`define ADD      4'b0000
`define SLL      4'b0001
`define SLT      4'b0010
`define SLTU     4'b0011
`define XOR      4'b0100
`define SRL      4'b0101
`define OR       4'b0110
`define AND      4'b0111
`define BEQ      4'b1000
`define BNE      4'b1001
`define JAL_JALR 4'b1010
`define SUB      4'b1011
`define BLT      4'b1100
// BGE shares its code with SRA; the ALU tells them apart with ex_is_branch.
`define BGE      4'b1101
`define SRA      4'b1101
`define BLTU     4'b1110
`define BGEU     4'b1111

`define OP       7'b0110011
`define OP_IMM   7'b0010011
`define LOAD     7'b0000011
`define STORE    7'b0100011
`define BRANCH   7'b1100011
`define JAL      7'b1101111
`define JALR     7'b1100111
`define LUI      7'b0110111
`define AUIPC    7'b0010111

`endif

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes RV32I, detects RAW hazards, drops wrong-path work on flush.
// Define DECODE_FWD_EN to add EX/MEM operand forwarding (only load-use then stalls).
`include "defines.sv"

module decode_issue
    import decode_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic            if_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
`ifdef DECODE_FWD_EN
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic [XLEN-1:0] mem_fwd_data,
`endif
    input  logic            ex_flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_aluIn1,
    output logic [XLEN-1:0] ex_aluIn2,
    output logic [3:0]      ex_aluOP,
    output logic [XLEN-1:0] ex_target,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic            ex_is_branch,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rdIdx, rs1Idx, rs2Idx;
    imm_t            imm;
    logic            useRs1, useRs2;
    logic            exMatch1, exMatch2, memMatch1, memMatch2;
    logic [XLEN-1:0] op1, op2;
    logic            hazard, advance, writesRd;
    exBundle_t       nxt, exQ;
    logic            exValidQ;

    assign opcode   = if_instr[6:0];
    assign rdIdx    = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign rs1Idx   = if_instr[19:15];
    assign rs2Idx   = if_instr[24:20];
    assign funct7b5 = if_instr[30];

    decode_issue_imm_gen uImmGen (
        .instr(if_instr[31:7]),
        .imm  (imm)
    );

    assign {useRs1, useRs2} = srcUse(opcode);

    // x0 is excluded up front so it never stalls and never takes a forwarded value.
    assign exMatch1  = useRs1 && (rs1Idx != 5'd0) && ex_valid && ex_we && (ex_rd == rs1Idx);
    assign exMatch2  = useRs2 && (rs2Idx != 5'd0) && ex_valid && ex_we && (ex_rd == rs2Idx);
    assign memMatch1 = useRs1 && (rs1Idx != 5'd0) && mem_we && (mem_rd == rs1Idx);
    assign memMatch2 = useRs2 && (rs2Idx != 5'd0) && mem_we && (mem_rd == rs2Idx);

`ifdef DECODE_FWD_EN
    assign op1    = exMatch1 ? ex_fwd_data : (memMatch1 ? mem_fwd_data : rs1_data);
    assign op2    = exMatch2 ? ex_fwd_data : (memMatch2 ? mem_fwd_data : rs2_data);
    assign hazard = if_valid && ex_is_load && (exMatch1 || exMatch2);
`else
    assign op1    = rs1_data;
    assign op2    = rs2_data;
    assign hazard = if_valid && (exMatch1 || exMatch2 || memMatch1 || memMatch2);
`endif

    assign advance  = ex_ready || !ex_valid;
    assign if_ready = ex_flush || (advance && !hazard);

    always_comb begin
        // NOTE: defaults come first so every path assigns every field and no latch is inferred.
        nxt      = resetBundle();
        writesRd = 1'b0;
        case (opcode)
            `OP: begin
                nxt.aluIn1 = op1;
                nxt.aluIn2 = op2;
                nxt.aluOp  = aluOpFor(funct3, funct7b5, 1'b1);
                writesRd   = 1'b1;
            end
            `OP_IMM: begin
                nxt.aluIn1 = op1;
                nxt.aluIn2 = (funct3 == 3'd1 || funct3 == 3'd5) ? {27'd0, rs2Idx} : imm.immI;
                nxt.aluOp  = aluOpFor(funct3, funct7b5, 1'b0);
                writesRd   = 1'b1;
            end
            `LOAD: begin
                nxt.aluIn1 = op1;
                nxt.aluIn2 = imm.immI;
                nxt.isLoad = 1'b1;
                writesRd   = 1'b1;
            end
            `STORE: begin
                nxt.aluIn1    = op1;
                nxt.aluIn2    = imm.immS;
                nxt.storeData = op2;
                nxt.isStore   = 1'b1;
            end
            `BRANCH: begin
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    nxt.illegal = 1'b1;
                end else begin
                    nxt.aluIn1   = op1;
                    nxt.aluIn2   = op2;
                    nxt.aluOp    = branchOp(funct3);
                    nxt.target   = if_pc + imm.immB;
                    nxt.isBranch = 1'b1;
                end
            end
            `JAL: begin
                nxt.aluIn1 = if_pc;
                nxt.aluIn2 = 32'd4;
                nxt.aluOp  = `JAL_JALR;
                nxt.target = if_pc + imm.immJ;
                writesRd   = 1'b1;
            end
            `JALR: begin
                nxt.aluIn1 = if_pc;
                nxt.aluIn2 = 32'd4;
                nxt.aluOp  = `JAL_JALR;
                nxt.target = (op1 + imm.immI) & ~32'd1;
                writesRd   = 1'b1;
            end
            `LUI: begin
                nxt.aluIn2 = imm.immU;
                writesRd   = 1'b1;
            end
            `AUIPC: begin
                nxt.aluIn1 = if_pc;
                nxt.aluIn2 = imm.immU;
                writesRd   = 1'b1;
            end
            default: nxt.illegal = 1'b1;
        endcase
        nxt.rd = writesRd ? rdIdx : 5'd0;
        nxt.we = writesRd && (rdIdx != 5'd0);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole EX register is reset, not just valid, so EX never sees stale fields.
            exValidQ <= 1'b0;
            exQ      <= resetBundle();
        end else if (ex_flush) begin
            exValidQ <= 1'b0;
        end else if (advance) begin
            exValidQ <= if_valid && !hazard;
            exQ      <= nxt;
        end
    end

    assign ex_valid      = exValidQ;
    assign ex_aluIn1     = exQ.aluIn1;
    assign ex_aluIn2     = exQ.aluIn2;
    assign ex_aluOP      = exQ.aluOp;
    assign ex_target     = exQ.target;
    assign ex_store_data = exQ.storeData;
    assign ex_rd         = exQ.rd;
    assign ex_we         = exQ.we;
    assign ex_is_load    = exQ.isLoad;
    assign ex_is_store   = exQ.isStore;
    assign ex_is_branch  = exQ.isBranch;
    assign ex_illegal    = exQ.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected EX bundles are queued at issue and
// compared when the EX register shows them. Builds with or without DECODE_FWD_EN.
module tb_decode_issue;
    import decode_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        if_ready;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  mem_rd;
    logic        mem_we;
`ifdef DECODE_FWD_EN
    logic [31:0] ex_fwd_data, mem_fwd_data;
`endif
    logic        ex_flush, ex_ready;
    logic        ex_valid;
    logic [31:0] ex_aluIn1, ex_aluIn2, ex_target, ex_store_data;
    logic [3:0]  ex_aluOP;
    logic [4:0]  ex_rd;
    logic        ex_we, ex_is_load, ex_is_store, ex_is_branch, ex_illegal;

    int errors = 0;
    int checks = 0;
    exBundle_t expQ[$];

    always #5 clk = ~clk;

    decode_issue dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
`ifdef DECODE_FWD_EN
        .ex_fwd_data  (ex_fwd_data),
        .mem_fwd_data (mem_fwd_data),
`endif
        .ex_flush     (ex_flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_aluIn1    (ex_aluIn1),
        .ex_aluIn2    (ex_aluIn2),
        .ex_aluOP     (ex_aluOP),
        .ex_target    (ex_target),
        .ex_store_data(ex_store_data),
        .ex_rd        (ex_rd),
        .ex_we        (ex_we),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_is_branch (ex_is_branch),
        .ex_illegal   (ex_illegal)
    );

    function automatic exBundle_t mk(input logic [31:0] a1, input logic [31:0] a2,
                                     input logic [3:0] op, input logic [31:0] tgt,
                                     input logic [31:0] sd, input logic [4:0] rd,
                                     input logic we, input logic ld, input logic st,
                                     input logic br, input logic ill);
        exBundle_t b;
        b.aluIn1 = a1;  b.aluIn2 = a2;  b.aluOp = op;  b.target = tgt;
        b.storeData = sd;  b.rd = rd;  b.we = we;  b.isLoad = ld;
        b.isStore = st;  b.isBranch = br;  b.illegal = ill;
        return b;
    endfunction

    function automatic exBundle_t sampleEx();
        return mk(ex_aluIn1, ex_aluIn2, ex_aluOP, ex_target, ex_store_data, ex_rd,
                  ex_we, ex_is_load, ex_is_store, ex_is_branch, ex_illegal);
    endfunction

    function automatic exBundle_t popExp();
        exBundle_t b;
        b = 'x;
        if (expQ.size() != 0) b = expQ.pop_front();
        return b;
    endfunction

    task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2);
        if_valid = 1'b1;  if_instr = instr;  if_pc = pc;  rs1_data = r1;  rs2_data = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exBundle_t got;
        rst = 1'b1;  if_valid = 1'b0;  if_instr = '0;  if_pc = '0;  rs1_data = '0;  rs2_data = '0;
        mem_rd = '0;  mem_we = 1'b0;  ex_flush = 1'b0;  ex_ready = 1'b1;
`ifdef DECODE_FWD_EN
        ex_fwd_data = '0;  mem_fwd_data = '0;
`endif
        tick();
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ex_valid); end
        got = sampleEx();
        checks++;
        if (got !== mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_bundle: got %h", got);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", if_ready); end
    endtask

    task automatic test_alu();
        logic [31:0] instrs[7], pcs[7], r1s[7], r2s[7];
        exBundle_t   exps[7];
        exBundle_t   got, exp;
        instrs = '{32'h00500093, 32'h40628233, 32'h40345393, 32'h123454B7,
                   32'h00001517, 32'h0063A623, 32'h020000EF};
        pcs    = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118};
        r1s    = '{32'h0, 32'h50, 32'h80000000, 32'h1111, 32'h2222, 32'h2000, 32'h3333};
        r2s    = '{32'hDEAD, 32'h20, 32'h9, 32'h4444, 32'h5555, 32'hCAFEF00D, 32'h6666};
        exps[0] = mk(0, 5, ALU_ADD, 0, 0, 1, 1, 0, 0, 0, 0);
        exps[1] = mk(32'h50, 32'h20, ALU_SUB, 0, 0, 4, 1, 0, 0, 0, 0);
        exps[2] = mk(32'h80000000, 3, ALU_SRA, 0, 0, 7, 1, 0, 0, 0, 0);
        exps[3] = mk(0, 32'h12345000, ALU_ADD, 0, 0, 9, 1, 0, 0, 0, 0);
        exps[4] = mk(32'h110, 32'h1000, ALU_ADD, 0, 0, 10, 1, 0, 0, 0, 0);
        exps[5] = mk(32'h2000, 12, ALU_ADD, 0, 32'hCAFEF00D, 0, 0, 0, 1, 0, 0);
        exps[6] = mk(32'h118, 4, ALU_JAL_JALR, 32'h138, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            present(instrs[i], pcs[i], r1s[i], r2s[i]);
            @(negedge clk);
            checks++;
            if (if_ready !== 1'b1) begin errors++; $display("FAIL alu_ready[%0d]: got %b exp 1", i, if_ready); end
            expQ.push_back(exps[i]);
            tick();
            checks++;
            if (ex_valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d]: got %b exp 1", i, ex_valid); end
            got = sampleEx();
            exp = popExp();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL alu_bundle[%0d]: got %h exp %h", i, got, exp); end
        end
    endtask

    task automatic test_load_use();
        exBundle_t   got, exp;
        logic [31:0] addOp;
        present(32'h0002A103, 32'h120, 32'h400, 32'h0);
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL lw_ready: got %b exp 1", if_ready); end
        expQ.push_back(mk(32'h400, 0, ALU_ADD, 0, 0, 2, 1, 1, 0, 0, 0));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL lw_bundle: got %h exp %h", got, exp); end
        present(32'h002101B3, 32'h124, 32'h55, 32'h55);
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL loaduse_stall: got %b exp 0", if_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble: got %b exp 0", ex_valid); end
`ifdef DECODE_FWD_EN
        mem_rd = 5'd2;  mem_we = 1'b1;  mem_fwd_data = 32'hBEEF0001;
        addOp = 32'hBEEF0001;
`else
        addOp = 32'h55;
`endif
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL loaduse_resume: got %b exp 1", if_ready); end
        expQ.push_back(mk(addOp, addOp, ALU_ADD, 0, 0, 3, 1, 0, 0, 0, 0));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL loaduse_add: got %h exp %h", got, exp); end
        mem_we = 1'b0;
    endtask

    task automatic test_forward();
        exBundle_t   got, exp;
        logic [31:0] srcVal;
        present(32'h00118593, 32'h128, 32'h77, 32'h0);
`ifdef DECODE_FWD_EN
        ex_fwd_data = 32'h12340000;  mem_rd = 5'd3;  mem_we = 1'b1;  mem_fwd_data = 32'hBEEF;
        srcVal = 32'h12340000;
`else
        srcVal = 32'h77;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL ex_dep_stall: got %b exp 0", if_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL ex_dep_bubble: got %b exp 0", ex_valid); end
        mem_rd = 5'd3;  mem_we = 1'b1;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL mem_dep_stall: got %b exp 0", if_ready); end
        tick();
        mem_we = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL dep_issue_ready: got %b exp 1", if_ready); end
        expQ.push_back(mk(srcVal, 1, ALU_ADD, 0, 0, 11, 1, 0, 0, 0, 0));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL dep_issue: got %h exp %h", got, exp); end
        mem_we = 1'b0;
    endtask

    task automatic test_x0();
        exBundle_t got, exp;
        present(32'h000006B3, 32'h12C, 32'h0, 32'h0);
        mem_rd = 5'd0;  mem_we = 1'b1;
`ifdef DECODE_FWD_EN
        mem_fwd_data = 32'hFFFF;
`endif
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL x0_no_hazard: got %b exp 1", if_ready); end
        expQ.push_back(mk(0, 0, ALU_ADD, 0, 0, 13, 1, 0, 0, 0, 0));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL x0_operands: got %h exp %h", got, exp); end
        mem_we = 1'b0;
    endtask

    task automatic test_branch();
        exBundle_t got, exp;
        present(32'h00208863, 32'h200, 32'h11, 32'h22);
        expQ.push_back(mk(32'h11, 32'h22, ALU_BEQ, 32'h210, 0, 0, 0, 0, 0, 1, 0));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL beq_bundle: got %h exp %h", got, exp); end
        present(32'h0020A863, 32'h204, 32'h11, 32'h22);
        expQ.push_back(mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL bad_branch: got %h exp %h", got, exp); end
        present(32'h00208863, 32'h208, 32'h11, 32'h22);
        ex_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", if_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b exp 0", ex_valid); end
        ex_flush = 1'b0;
    endtask

    task automatic test_stall();
        exBundle_t got, exp, held;
        held = mk(32'h300, 4, ALU_JAL_JALR, 32'h100A, 0, 1, 1, 0, 0, 0, 0);
        present(32'h008280E7, 32'h300, 32'h1003, 32'h0);
        expQ.push_back(held);
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL jalr_bundle: got %h exp %h", got, exp); end
        ex_ready = 1'b0;
        present(32'h00700613, 32'h304, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b exp 0", i, if_ready); end
            tick();
            got = sampleEx();
            checks++;
            if (got !== held || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, got, held); end
        end
        ex_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL stall_flush_ready: got %b exp 1", if_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_flush_drop: got %b exp 0", ex_valid); end
        ex_flush = 1'b0;
        ex_ready = 1'b1;
        expQ.push_back(mk(0, 7, ALU_ADD, 0, 0, 12, 1, 0, 0, 0, 0));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL after_stall: got %h exp %h", got, exp); end
    endtask

    task automatic test_illegal_and_reset();
        exBundle_t got, exp;
        present(32'h000002FF, 32'h400, 32'h0, 32'h0);
        expQ.push_back(mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        got = sampleEx();
        exp = popExp();
        checks++;
        if (got !== exp || ex_valid !== 1'b1) begin errors++; $display("FAIL illegal: got %h exp %h", got, exp); end
        ex_ready = 1'b0;
        present(32'h020000EF, 32'h404, 32'h0, 32'h0);
        tick();
        ex_flush = 1'b1;
        rst      = 1'b1;
        tick();
        got = sampleEx();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", ex_valid); end
        checks++;
        if (got !== mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL midrst_bundle: got %h", got);
        end
        rst = 1'b0;  ex_flush = 1'b0;  ex_ready = 1'b1;  if_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b exp 1", if_ready); end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d exp 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_use();
        test_forward();
        test_x0();
        test_branch();
        test_stall();
        test_illegal_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
